// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: scans N_KEYS raw key lines with one shared stability
// counter. Each press goes through synchronise, qualify (STABLE), emit and
// release-wait (HOLD), and yields one code with a single-cycle valid strobe.
//
// Output handshake: valid is a one-cycle strobe with no back-pressure; the
// consumer must take code in the cycle valid is high. code then holds its
// value until the next accepted press. multi_err is an independent
// one-cycle strobe.
module keypad_scan_ctrl #(
  parameter int N_KEYS         = 10,
  parameter int CODE_W         = 4,
  parameter int STABLE_CYCLES  = 8,
  parameter int RELEASE_CYCLES = 8
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [N_KEYS-1:0] keys,
  input  logic              enable,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic              busy,
  output logic              multi_err
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam int REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam int KC_W  = $clog2(N_KEYS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STABLE = 2'd1,
    EMIT   = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t            state;
  logic [N_KEYS-1:0] s1;
  logic [N_KEYS-1:0] s2;
  logic [N_KEYS-1:0] ks;
  logic [CNT_W-1:0]  cnt;
  logic [REL_W-1:0]  rel;
  logic [CODE_W-1:0] cap;

  logic [KC_W-1:0]   key_count;
  logic [CODE_W-1:0] key_idx;
  logic              is_one;
  logic              is_multi;
  logic              cap_match;

  assign ks = s2;

  // Two-flop synchroniser for the asynchronous key lines.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= keys;
      s2 <= s1;
    end
  end

  // Decode the synchronised lines: how many are high, which one, and
  // whether they still equal exactly the captured key.
  always_comb begin
    key_count = '0;
    key_idx   = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (ks[i]) begin
        key_count = key_count + 1'b1;
        key_idx   = CODE_W'(i);
      end
    end
    is_one    = (key_count == KC_W'(1));
    is_multi  = (key_count > KC_W'(1));
    cap_match = (ks == (N_KEYS'(1) << cap));
  end

  // Press sequencer: qualify, emit once, then wait for a clean release.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state     <= IDLE;
      cnt       <= '0;
      rel       <= '0;
      cap       <= '0;
      code      <= '0;
      valid     <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      multi_err <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && is_one) begin
            cap   <= key_idx;
            cnt   <= CNT_W'(1);
            state <= STABLE;
          end else if (is_multi) begin
            // Reported even while disabled so the front panel fault is visible.
            multi_err <= 1'b1;
          end
        end
        STABLE: begin
          if (enable && cap_match) begin
            if (cnt == CNT_LAST) begin
              code  <= cap;
              valid <= 1'b1;
              state <= EMIT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            // Bounce, a different key, extra keys or disable: start over.
            if (is_multi) begin
              multi_err <= 1'b1;
            end
            cnt   <= '0;
            state <= IDLE;
          end
        end
        EMIT: begin
          rel   <= '0;
          state <= HOLD;
        end
        HOLD: begin
          // Any key activity restarts the release window; a held key
          // never produces a second strobe.
          if (ks == '0) begin
            if (rel == REL_LAST) begin
              state <= IDLE;
            end else begin
              rel <= rel + 1'b1;
            end
          end else begin
            rel <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // busy is derived only from the state register.
  assign busy = (state != IDLE);

endmodule
